// File: rtl/compfft_pkg.sv
// rtl/compfft_pkg.sv - shared types and helpers for the 4-point FFT/IFFT family
// Holds the frame state encoding, the guard-bit width of the full-precision
// bins and the scale-then-saturate helper used when narrowing bins to W bits.
package compfft_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // Two butterfly stages each grow the magnitude by one bit.
    localparam int GUARD_BITS = 2;

    function automatic int int_width(input int w);
        return w + GUARD_BITS;
    endfunction

    // Arithmetic right shift (floor toward -inf), then clamp to a signed w-bit range.
    function automatic int sat_shift(input int v, input int shift, input int w);
        int s;
        int hi;
        int lo;
        s  = v >>> shift;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/compfft4_stream_if.sv
// rtl/compfft4_stream_if.sv - sample-in / bin-out stream bundle for compfft4_stream
// Ports: in_valid/in_ready/in_re/in_im carry time samples toward the block;
// out_valid/out_ready/out_re/out_im/out_idx/out_last carry frequency bins away.
// slave = the FFT block, master = the sample source plus bin sink.
interface compfft4_stream_if #(
    parameter int W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [1:0]          out_idx;
    logic                out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/compfft2_bfly.sv
// rtl/compfft2_bfly.sv - combinational complex radix-2 butterfly
// Ports: a_re/a_im, b_re/b_im (signed W) in; sum = a+b and dif = a-b
// (signed W+1, never overflows) out.
module compfft2_bfly #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W:0]   sum_re,
    output logic signed [W:0]   sum_im,
    output logic signed [W:0]   dif_re,
    output logic signed [W:0]   dif_im
);
    logic signed [W:0] ae_re;
    logic signed [W:0] ae_im;
    logic signed [W:0] be_re;
    logic signed [W:0] be_im;

    assign ae_re = $signed({a_re[W-1], a_re});
    assign ae_im = $signed({a_im[W-1], a_im});
    assign be_re = $signed({b_re[W-1], b_re});
    assign be_im = $signed({b_im[W-1], b_im});

    assign sum_re = ae_re + be_re;
    assign sum_im = ae_im + be_im;
    assign dif_re = ae_re - be_re;
    assign dif_im = ae_im - be_im;
endmodule

// File: rtl/compfft4_stream.sv
// rtl/compfft4_stream.sv - streaming 4-point radix-2 forward FFT
// Ports: clk, rst (sync, active high), ce (global hold), bus (slave modport):
// four samples are collected over in_*, one compute cycle forms the scaled and
// saturated bins, then bins 0..3 are emitted over out_* with out_last on bin 3.
module compfft4_stream
    import compfft_pkg::*;
#(
    parameter int W     = 8,
    parameter int SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    compfft4_stream_if.slave   bus
);
    localparam int IW = int_width(W);

    state_t state;
    state_t state_nxt;

    logic [1:0]          cnt;
    logic [1:0]          bcnt;
    logic signed [W-1:0] x_re   [4];
    logic signed [W-1:0] x_im   [4];
    logic signed [W-1:0] bin_re [4];
    logic signed [W-1:0] bin_im [4];

    // Stage 1: even pair (x0,x2) and odd pair (x1,x3).
    logic signed [W:0] s02_re, s02_im, d02_re, d02_im;
    logic signed [W:0] s13_re, s13_im, d13_re, d13_im;
    logic signed [W:0] d13_re_neg;

    compfft2_bfly #(.W(W)) u_bfly_even (
        .a_re(x_re[0]), .a_im(x_im[0]), .b_re(x_re[2]), .b_im(x_im[2]),
        .sum_re(s02_re), .sum_im(s02_im), .dif_re(d02_re), .dif_im(d02_im)
    );

    compfft2_bfly #(.W(W)) u_bfly_odd (
        .a_re(x_re[1]), .a_im(x_im[1]), .b_re(x_re[3]), .b_im(x_im[3]),
        .sum_re(s13_re), .sum_im(s13_im), .dif_re(d13_re), .dif_im(d13_im)
    );

    // -j * (d13_re + j d13_im) = d13_im - j d13_re. d13_re is a difference of
    // two W-bit values so it never reaches -2^W and the negation cannot wrap.
    assign d13_re_neg = -d13_re;

    // Stage 2: X0/X2 from the sums, X1/X3 from the twiddled differences.
    logic signed [IW-1:0] full_re [4];
    logic signed [IW-1:0] full_im [4];

    compfft2_bfly #(.W(W+1)) u_bfly_s2_even (
        .a_re(s02_re), .a_im(s02_im), .b_re(s13_re), .b_im(s13_im),
        .sum_re(full_re[0]), .sum_im(full_im[0]),
        .dif_re(full_re[2]), .dif_im(full_im[2])
    );

    compfft2_bfly #(.W(W+1)) u_bfly_s2_odd (
        .a_re(d02_re), .a_im(d02_im), .b_re(d13_im), .b_im(d13_re_neg),
        .sum_re(full_re[1]), .sum_im(full_im[1]),
        .dif_re(full_re[3]), .dif_im(full_im[3])
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ce gating lives in the state register.
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (bus.in_valid && cnt == 2'd3) state_nxt = COMPUTE;
            COMPUTE: state_nxt = OUTPUT;
            OUTPUT:  if (bus.out_ready && bcnt == 2'd3) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Outputs; the bin mux follows bcnt, so it holds whenever bcnt holds.
    always_comb begin
        bus.in_ready  = (state == COLLECT);
        bus.out_valid = (state == OUTPUT);
        bus.out_re    = bin_re[bcnt];
        bus.out_im    = bin_im[bcnt];
        bus.out_idx   = bcnt;
        bus.out_last  = (state == OUTPUT) && (bcnt == 2'd3);
    end

    // Sample buffer, bin buffer and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            bcnt <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                x_re[k]   <= '0;
                x_im[k]   <= '0;
                bin_re[k] <= '0;
                bin_im[k] <= '0;
            end
        end else if (ce) begin
            unique case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        x_re[cnt] <= bus.in_re;
                        x_im[cnt] <= bus.in_im;
                        cnt       <= cnt + 2'd1;
                    end
                end
                COMPUTE: begin
                    for (int k = 0; k < 4; k++) begin
                        bin_re[k] <= W'(sat_shift(int'(full_re[k]), SHIFT, W));
                        bin_im[k] <= W'(sat_shift(int'(full_im[k]), SHIFT, W));
                    end
                    bcnt <= 2'd0;
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            cnt <= 2'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_compfft4_stream.sv
// tb/tb_compfft4_stream.sv - self-checking bench for compfft4_stream
// Two instances (SHIFT=2 and SHIFT=0) share one stimulus stream.
module tb_compfft4_stream;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    logic in_valid;
    logic out_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;

    always #5 clk = ~clk;

    compfft4_stream_if #(.W(W)) bus2 ();
    compfft4_stream_if #(.W(W)) bus0 ();

    assign bus2.in_valid  = in_valid;
    assign bus2.in_re     = in_re;
    assign bus2.in_im     = in_im;
    assign bus2.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_re     = in_re;
    assign bus0.in_im     = in_im;
    assign bus0.out_ready = out_ready;

    compfft4_stream #(.W(W), .SHIFT(2)) dut2 (.clk(clk), .rst(rst), .ce(ce), .bus(bus2));
    compfft4_stream #(.W(W), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .ce(ce), .bus(bus0));

    int checks = 0;
    int failures = 0;

    int fx_re [4];
    int fx_im [4];
    int e_re  [4];
    int e_im  [4];
    int m2_re [4];
    int m2_im [4];
    int m0_re [4];
    int m0_im [4];

    typedef struct packed {
        logic [3:0][7:0] xr;
        logic [3:0][7:0] xi;
        logic [3:0][7:0] er;
        logic [3:0][7:0] ei;
    } vec_t;

    vec_t  tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] pk(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        return r;
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Direct DFT definition: X[k] = sum x[n] * (-j)^(k*n).
    task automatic ref_dft();
        for (int k = 0; k < 4; k++) begin
            int ar;
            int ai;
            ar = 0;
            ai = 0;
            for (int n = 0; n < 4; n++) begin
                int c;
                int d;
                case ((k * n) % 4)
                    0: begin c = 1;  d = 0;  end
                    1: begin c = 0;  d = -1; end
                    2: begin c = -1; d = 0;  end
                    default: begin c = 0; d = 1; end
                endcase
                ar += fx_re[n] * c - fx_im[n] * d;
                ai += fx_re[n] * d + fx_im[n] * c;
            end
            m2_re[k] = sat8(ar >>> 2);
            m2_im[k] = sat8(ai >>> 2);
            m0_re[k] = sat8(ar);
            m0_im[k] = sat8(ai);
        end
    endtask

    task automatic load_vec(input int i);
        for (int n = 0; n < 4; n++) begin
            fx_re[n] = int'($signed(tbl[i].xr[n]));
            fx_im[n] = int'($signed(tbl[i].xi[n]));
            e_re[n]  = int'($signed(tbl[i].er[n]));
            e_im[n]  = int'($signed(tbl[i].ei[n]));
        end
        ref_dft();
    endtask

    task automatic load_random();
        for (int n = 0; n < 4; n++) begin
            fx_re[n] = int'($urandom_range(0, 255)) - 128;
            fx_im[n] = int'($urandom_range(0, 255)) - 128;
        end
        ref_dft();
        for (int n = 0; n < 4; n++) begin
            e_re[n] = m2_re[n];
            e_im[n] = m2_im[n];
        end
    endtask

    task automatic send_frame(input int gap_max, input int stall_at);
        int  i;
        int  budget;
        bit  acc;
        i = 0;
        budget = 0;
        while (i < 4 && budget < 60) begin
            if (gap_max > 0 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, gap_max)) begin
                    @(posedge clk); #1;
                    budget++;
                end
            end
            if (i == stall_at) begin
                ce = 1'b0;
                in_valid = 1'b1;
                in_re = 8'sd99;
                in_im = -8'sd77;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("ce_hold_in_ready", int'(bus2.in_ready), 1);
                end
                ce = 1'b1;
            end
            in_valid = 1'b1;
            in_re = W'(fx_re[i]);
            in_im = W'(fx_im[i]);
            acc = bus2.in_ready && ce;
            @(posedge clk); #1;
            budget++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("send_accepted", i, 4);
        chk("lat_t1_out_valid", int'(bus2.out_valid), 0);
        chk("lat_t1_in_ready", int'(bus2.in_ready), 0);
        @(posedge clk); #1;
        chk("lat_t2_out_valid", int'(bus2.out_valid), 1);
    endtask

    task automatic chk_bin(input int k);
        chk($sformatf("idx2_b%0d", k), int'(bus2.out_idx), k);
        chk($sformatf("last2_b%0d", k), int'(bus2.out_last), (k == 3) ? 1 : 0);
        chk($sformatf("re2_b%0d", k), int'(bus2.out_re), e_re[k]);
        chk($sformatf("im2_b%0d", k), int'(bus2.out_im), e_im[k]);
        chk($sformatf("idx0_b%0d", k), int'(bus0.out_idx), k);
        chk($sformatf("re0_b%0d", k), int'(bus0.out_re), m0_re[k]);
        chk($sformatf("im0_b%0d", k), int'(bus0.out_im), m0_im[k]);
    endtask

    task automatic recv_frame(input int stall_bin, input int stall_n, input int rst_bin);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            while (!bus2.out_valid && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            chk($sformatf("valid_b%0d", k), int'(bus2.out_valid), 1);
            if (k == rst_bin) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("rst_out_out_valid", int'(bus2.out_valid), 0);
                chk("rst_out_in_ready", int'(bus2.in_ready), 1);
                chk("rst_out_out_last", int'(bus2.out_last), 0);
                return;
            end
            chk_bin(k);
            if (k == stall_bin) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    chk("stall_valid", int'(bus2.out_valid), 1);
                    chk_bin(k);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("end_out_valid", int'(bus2.out_valid), 0);
        chk("end_in_ready", int'(bus2.in_ready), 1);
    endtask

    initial begin
        tbl[0] = '{xr: pk(64, 0, 0, 0),       xi: pk(0, 0, 0, 0),
                   er: pk(16, 16, 16, 16),    ei: pk(0, 0, 0, 0)};
        tbl[1] = '{xr: pk(32, 32, 32, 32),    xi: pk(0, 0, 0, 0),
                   er: pk(32, 0, 0, 0),       ei: pk(0, 0, 0, 0)};
        tbl[2] = '{xr: pk(40, 0, -40, 0),     xi: pk(0, 40, 0, -40),
                   er: pk(0, 40, 0, 0),       ei: pk(0, 0, 0, 0)};
        tbl[3] = '{xr: pk(40, 0, -40, 0),     xi: pk(0, -40, 0, 40),
                   er: pk(0, 0, 0, 40),       ei: pk(0, 0, 0, 0)};
        tbl[4] = '{xr: pk(127, 127, 127, 127), xi: pk(-128, -128, -128, -128),
                   er: pk(127, 0, 0, 0),      ei: pk(-128, 0, 0, 0)};
        tbl[5] = '{xr: pk(-1, 0, 0, 0),       xi: pk(0, 0, 0, 0),
                   er: pk(-1, -1, -1, -1),    ei: pk(0, 0, 0, 0)};

        // Reset with ce low: reset must not depend on ce.
        rst = 1'b1;
        ce = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ce = 1'b1;
        chk("reset_in_ready", int'(bus2.in_ready), 1);
        chk("reset_out_valid", int'(bus2.out_valid), 0);
        chk("reset_out_re", int'(bus2.out_re), 0);
        chk("reset_out_im", int'(bus2.out_im), 0);
        chk("reset_out_idx", int'(bus2.out_idx), 0);
        chk("reset_out_last", int'(bus2.out_last), 0);

        for (int i = 0; i < 6; i++) begin
            load_vec(i);
            send_frame(0, -1);
            recv_frame(-1, 0, -1);
        end

        // Backpressure: out_ready low for 5 cycles during bin 1.
        load_random();
        send_frame(0, -1);
        recv_frame(1, 5, -1);

        // ce low for 3 cycles mid-collect with in_valid high.
        load_vec(3);
        send_frame(0, 2);
        recv_frame(-1, 0, -1);

        // Reset after 2 accepted samples, then a clean frame.
        load_random();
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1;
            in_re = W'(fx_re[n]);
            in_im = W'(fx_im[n]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_col_out_valid", int'(bus2.out_valid), 0);
        chk("rst_col_in_ready", int'(bus2.in_ready), 1);
        load_vec(2);
        send_frame(0, -1);
        recv_frame(-1, 0, -1);

        // Reset while bin 2 is on the output, then a clean frame.
        load_vec(4);
        send_frame(0, -1);
        recv_frame(-1, 0, 2);
        load_vec(5);
        send_frame(0, -1);
        recv_frame(-1, 0, -1);

        for (int f = 0; f < 20; f++) begin
            load_random();
            send_frame(2, -1);
            recv_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/compfft4_stream.md
Name: compfft4_stream

Overview:
- Streaming 4-point radix-2 forward FFT. It is the analysis-side counterpart of the team's 4-point IFFT.
- Accepts complex samples serially over a valid/ready handshake and buffers one frame of 4.
- Computes X[k] = sum x[n]·e^(−j2πkn/4) with a configurable right-shift scale, then emits bins 0..3 serially.
- Sits at the receive-side front end, between the sample source and the demapper.

Parameters:
- W, 8, signed width of each real/imag component on input and output.
- SHIFT, 2, arithmetic right-shift applied to the full-precision bin value. Legal range 0..2.

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- ce  input  1  clock enable; when low all state, counters and outputs hold
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample
- in_re  input  W  signed real part of input sample
- in_im  input  W  signed imag part of input sample
- out_valid  output  1  output bin valid
- out_ready  input  1  downstream accepts bin
- out_re  output  W  signed real part of bin
- out_im  output  W  signed imag part of bin
- out_idx  output  2  bin index k of current output
- out_last  output  1  high with bin 3

Behaviour:
- Reset (rst=1 at posedge, regardless of ce):
  - state=COLLECT, sample count=0, bin count=0.
  - in_ready=1, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0.
  - Sample buffer is cleared to 0.
  - A partial frame in flight is discarded; a partially emitted output frame is abandoned.
- ce=0: no state changes; registered outputs hold. The handshake is only evaluated when ce=1.
- COLLECT:
  - in_ready=1.
  - On ce & in_valid, the sample is stored at x[cnt] and cnt increments.
  - Accepting the 4th sample (cnt=3) moves to COMPUTE on the next cycle.
- COMPUTE (1 cycle):
  - in_ready=0.
  - Full-precision sums are formed at W+2 bits (sign-extend first):
    - X0 = x0+x1+x2+x3
    - X2 = x0−x1+x2−x3
    - X1re = x0r+x1i−x2r−x3i; X1im = x0i−x1r−x2i+x3r
    - X3re = x0r−x1i−x2r+x3i; X3im = x0i+x1r−x2i−x3r
  - Each component is arithmetic-shifted right by SHIFT (floor), then saturated to [−2^(W−1), 2^(W−1)−1].
  - Results are registered into a 4-entry bin buffer. Go to OUTPUT with bin count=0.
- OUTPUT:
  - out_valid=1; out_re/out_im/out_idx present bin[bcnt]; out_last=(bcnt==3).
  - On ce & out_ready, bcnt increments.
  - On acceptance of bin 3, the block returns to COLLECT with out_valid=0 next cycle and cnt=0.
  - out_ready low holds all output signals stable.
- Latency: the 4th input is accepted at cycle t; bin 0 is valid at t+2. Minimum frame period is 4+1+4 = 9 cycles.
- in_ready=0 throughout COMPUTE and OUTPUT. Input is not overlapped with output.

Decomposition:
- Shared package compfft_pkg holds:
  - the state encoding (COLLECT/COMPUTE/OUTPUT)
  - the W+2 internal width constant
  - a sat_shift function (shift then saturate), shared with any later scaled IFFT revision
- Natural sub-module: compfft2_bfly, a combinational radix-2 butterfly (a+b, a−b at W+1 bits).
  - Two instances form stage 1 on (x0,x2) and (x1,x3).
  - Stage 2 applies the −j twiddle to the odd difference.

Test Plan:
- Impulse, SHIFT=2: input (64,0),(0,0),(0,0),(0,0) -> bins 0..3 all (16,0); out_last only with idx 3; bin 0 valid 2 cycles after the 4th accept.
- DC, SHIFT=2: four samples (32,0) -> X0=(32,0), X1=X2=X3=(0,0).
- Tone, SHIFT=2: (40,0),(0,40),(−40,0),(0,−40) -> X1=(40,0), all others (0,0). The conjugate sequence (40,0),(0,−40),(−40,0),(0,40) -> X3=(40,0).
- Saturation, SHIFT=0: four samples (127,−128) -> X0=(127,−128) saturated, others (0,0). Negative floor check with SHIFT=2: x0=(−1,0), rest 0 -> all bins (−1,0).
- Backpressure and stall:
  - out_ready=0 for 5 cycles during bin 1 -> out_re/out_im/out_idx held, no bin skipped or repeated.
  - ce=0 mid-collect for 3 cycles, with in_valid high -> no sample captured; frame resumes correctly.
- Reset mid-operation: assert rst after 2 samples, and separately during bin 2 output -> next cycle out_valid=0, in_ready=1; the following clean frame produces correct bins with no stale data.
